uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Control and serialisation stage of the UART transmitter. It sits directly downstream of parity_calc and consumes its registered PAR_BIT. It accepts a parallel word from the upstream data source and issues the PAR_calc strobe to parity_calc. It then drives the serial line with start bit, data bits LSB first, an optional parity bit and a stop bit, one bit per CLK cycle. Baud pacing is provided by the CLK enable domain upstream and is outside this block.

Parameters:
WIDTH, 8, data word width in bits; must match parity_calc WIDTH; minimum 2.

Ports:
CLK  input  1  transmitter clock; one serial bit per cycle.
RST  input  1  asynchronous active-low reset.
P_DATA  input  WIDTH  parallel word; sampled only on the accept edge.
DATA_VALID  input  1  upstream request; P_DATA is valid.
PAR_EN  input  1  1 = frame includes parity bit; sampled on the accept edge.
PAR_BIT  input  1  parity bit from parity_calc, registered on the accept edge.
PAR_calc  output  1  combinational strobe to parity_calc; high exactly on accept cycles.
TX_OUT  output  1  serial line, registered; idle level 1.
BUSY  output  1  registered; high from the first cycle after acceptance through the stop bit.
TX_DONE  output  1  registered one-cycle pulse during the stop-bit cycle.

Behaviour:
- Reset (async, RST=0):
  - state=IDLE, TX_OUT=1, BUSY=0, TX_DONE=0.
  - Shift register, bit counter and latched PAR_EN are cleared to 0.
  - Reset mid-frame aborts the frame immediately; the line returns to 1 with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP. State, TX_OUT, BUSY and TX_DONE are all registered.
- Accept: in IDLE, when DATA_VALID=1 at a CLK edge:
  - P_DATA is loaded into the shift register and PAR_EN is latched.
  - The next state is START.
  - DATA_VALID outside IDLE is ignored; no queuing and no error flag.
- PAR_calc = DATA_VALID & (state==IDLE). parity_calc therefore captures the parity of the same P_DATA on the same edge. PAR_BIT is stable for the rest of the frame and is used without further qualification.
- Cycle timing, with acceptance at edge k:
  - After edge k: START, TX_OUT=0, BUSY=1.
  - After edges k+1 .. k+WIDTH: DATA, TX_OUT = bit 0 .. bit WIDTH-1 of the latched word (LSB first).
  - Bit counter runs 0..WIDTH-1; leave DATA when counter==WIDTH-1.
  - If latched PAR_EN=1, after edge k+WIDTH+1: PARITY, TX_OUT=PAR_BIT.
  - Next cycle: STOP, TX_OUT=1, BUSY=1, TX_DONE=1.
  - Next edge: IDLE, BUSY=0, TX_DONE=0, TX_OUT=1.
- Frame length is WIDTH+2 cycles without parity and WIDTH+3 with parity. At least one IDLE cycle always separates frames: the earliest next acceptance is the first edge on which state==IDLE.
- DATA_VALID held high continuously: a new frame is accepted at every IDLE cycle. The period is frame length + 1.
- P_DATA and PAR_EN changes during a frame have no effect on that frame.
- Bit counter width: $clog2(WIDTH). No wrap beyond WIDTH-1.
- Illegal or unused state encodings recover to IDLE with TX_OUT=1.

Test Plan:
- Reset behaviour: hold RST=0 for 3 cycles -> TX_OUT=1, BUSY=0, TX_DONE=0, PAR_calc=0 throughout, even with DATA_VALID=1.
- Even parity: WIDTH=8, P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 into parity_calc, DATA_VALID one cycle.
  - PAR_calc=1 for exactly that cycle.
  - TX_OUT after the accept edge = 0,1,0,1,0,0,1,0,1,0,1 (11 cycles).
  - TX_DONE high only on the final 1; BUSY falls one cycle later.
- Odd parity: same stimulus with PAR_TYP=1 -> parity slot = 1. Frame is 0,1,0,1,0,0,1,0,1,1,1.
- No parity: P_DATA=8'h0F, PAR_EN=0 -> frame 0,1,1,1,1,0,0,0,0,1 (10 cycles); no parity slot.
- Back-to-back: DATA_VALID held high with words 8'h01 then 8'hFE, PAR_EN=1.
  - The second acceptance occurs exactly 12 cycles after the first (11-cycle frame + 1 idle).
  - P_DATA changed mid-frame does not corrupt frame 1.
  - PAR_calc pulses only on the two accept cycles.
- Reset mid-frame: assert RST=0 asynchronously during the 4th data bit.
  - TX_OUT=1 and BUSY=0 immediately.
  - After release, a fresh 8'h3C frame transmits correctly from the start bit.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame serialiser (start, LSB-first data, optional parity, stop)
module uart_tx_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             PAR_BIT,
  output logic             PAR_calc,
  output logic             TX_OUT,
  output logic             BUSY,
  output logic             TX_DONE
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_par_en;
  // Gated by RST so parity_calc never captures while the frame logic is held in reset
  assign PAR_calc = DATA_VALID & RST & (r_state == IDLE);
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_par_en <= 1'b0;
      TX_OUT   <= 1'b1;
      BUSY     <= 1'b0;
      TX_DONE  <= 1'b0;
    end else begin
      TX_DONE <= 1'b0;
      case (r_state)
        IDLE: if (DATA_VALID) begin
          r_shift  <= P_DATA;
          r_par_en <= PAR_EN;
          r_state  <= START;
          TX_OUT   <= 1'b0;
          BUSY     <= 1'b1;
        end
        START: begin
          r_state <= DATA;
          TX_OUT  <= r_shift[0];
          r_shift <= {1'b0, r_shift[WIDTH-1:1]};
        end
        DATA: if (r_cnt == LAST) begin
          r_cnt   <= '0;
          r_state <= r_par_en ? PARITY : STOP;
          TX_OUT  <= r_par_en ? PAR_BIT : 1'b1;
          TX_DONE <= ~r_par_en;
        end else begin
          r_cnt   <= r_cnt + 1'b1;
          TX_OUT  <= r_shift[0];
          r_shift <= {1'b0, r_shift[WIDTH-1:1]};
        end
        PARITY: begin
          r_state <= STOP;
          TX_OUT  <= 1'b1;
          TX_DONE <= 1'b1;
        end
        STOP: begin
          r_state <= IDLE;
          TX_OUT  <= 1'b1;
          BUSY    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          TX_OUT  <= 1'b1;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl with a behavioural parity_calc
module tb_uart_tx_ctrl;
  localparam int W = 8;
  logic         CLK = 1'b0, RST = 1'b0, DATA_VALID = 1'b0, PAR_EN = 1'b0, par_typ = 1'b0;
  logic         PAR_BIT, PAR_calc, TX_OUT, BUSY, TX_DONE;
  logic [W-1:0] P_DATA = '0;
  int n_cmp = 0, n_err = 0, cyc = 0;
  typedef struct {logic tx; logic done; logic last;} exp_t;
  exp_t q[$];
  int   acc[$];
  logic expect_idle = 1'b0;

  uart_tx_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN),
    .PAR_BIT(PAR_BIT), .PAR_calc(PAR_calc), .TX_OUT(TX_OUT), .BUSY(BUSY), .TX_DONE(TX_DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or negedge RST)
    if (!RST) PAR_BIT <= 1'b0;
    else if (PAR_calc) PAR_BIT <= par_typ ? ~^P_DATA : ^P_DATA;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) if (RST) begin
    if (PAR_calc) acc.push_back(cyc);
    if (expect_idle) begin
      chk("busy_fall", BUSY, 0);
      chk("done_fall", TX_DONE, 0);
      chk("idle_line", TX_OUT, 1);
      expect_idle = 1'b0;
    end else if (BUSY) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL busy_extra: BUSY=1 with no expected bit at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("tx_bit", TX_OUT, e.tx);
        chk("tx_done", TX_DONE, e.done);
        expect_idle = e.last;
      end
    end
  end

  task automatic push_frame(input logic [15:0] b, input int len);
    for (int i = 0; i < len; i++) q.push_back('{b[len-1-i], i == len - 1, i == len - 1});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && (q.size() != 0 || expect_idle); i++) @(posedge CLK);
    if (q.size() != 0 || expect_idle) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: %0d bits outstanding", q.size());
    end
    repeat (2) @(posedge CLK);
  endtask

  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt,
                      input logic [15:0] b, input int len);
    int n0;
    n0 = acc.size();
    @(posedge CLK) #1;
    P_DATA = d; PAR_EN = pe; par_typ = pt; DATA_VALID = 1'b1;
    push_frame(b, len);
    @(posedge CLK) #1;
    DATA_VALID = 1'b0;
    wait_done();
    chk("par_calc_pulses", acc.size() - n0, 1);
  endtask

  initial begin
    int n0;
    DATA_VALID = 1'b1; P_DATA = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_tx", TX_OUT, 1);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", TX_DONE, 0);
      chk("rst_par_calc", PAR_calc, 0);
    end
    @(posedge CLK) #1;
    DATA_VALID = 1'b0; RST = 1'b1;
    repeat (2) @(posedge CLK);
    send(8'hA5, 1'b1, 1'b0, 16'b01010010101, 11);
    send(8'hA5, 1'b1, 1'b1, 16'b01010010111, 11);
    send(8'h0F, 1'b0, 1'b0, 16'b0111100001, 10);
    // Back-to-back with DATA_VALID held; P_DATA swapped during frame 1
    n0 = acc.size();
    @(posedge CLK) #1;
    P_DATA = 8'h01; PAR_EN = 1'b1; par_typ = 1'b0; DATA_VALID = 1'b1;
    push_frame(16'b01000000011, 11);
    push_frame(16'b00111111111, 11);
    @(posedge CLK) #1;
    P_DATA = 8'hFE;
    for (int i = 0; i < 30 && acc.size() < n0 + 2; i++) @(posedge CLK);
    #1 DATA_VALID = 1'b0;
    wait_done();
    chk("b2b_pulses", acc.size() - n0, 2);
    if (acc.size() >= n0 + 2) chk("b2b_spacing", acc[n0+1] - acc[n0], 12);
    // Abort a frame of zeros during its 4th data bit
    @(posedge CLK) #1;
    P_DATA = 8'h00; PAR_EN = 1'b0; DATA_VALID = 1'b1;
    push_frame(16'b0000000001, 10);
    @(posedge CLK) #1;
    DATA_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #1 chk("pre_abort_tx", TX_OUT, 0);
    #1 RST = 1'b0;
    #1;
    chk("abort_tx", TX_OUT, 1);
    chk("abort_busy", BUSY, 0);
    chk("abort_done", TX_DONE, 0);
    q.delete();
    expect_idle = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    send(8'h3C, 1'b0, 1'b0, 16'b0001111001, 10);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
